// File: rtl/memory_stage.sv
// Memory stage: executes loads and stores on a req/ack bus, stalls while an
// access is in flight, issues the PC redirect and registers writeback results.
//
// Ports:
//   clk, async_rst        rising-edge clock, asynchronous active-high reset
//   clk_en, invalidate    pipeline advance enable, writeback squash (sync)
//   ctr_in                [0]mem_read [1]mem_write [2]reg_write [4:3]wb_sel
//   inst_in, alu_in       instruction (fn3, rd) and address / ALU result
//   inc_pc_in, rs2_in     PC+1 (word units) and store data
//   branch_in             taken branch / jump
//   bus_*                 req/ack data bus (request side registered)
//   mem_stall, redirect*  upstream hold and PC redirect
//   mem_*                 hazard / forwarding information for this stage
//   misaligned, bus_error one-cycle fault pulses
//   wb_valid/rd/data      writeback register
module memory_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        async_rst,
    input  logic        clk_en,
    input  logic        invalidate,
    input  logic [4:0]  ctr_in,
    input  logic [31:0] inst_in,
    input  logic [31:0] alu_in,
    input  logic [29:0] inc_pc_in,
    input  logic [31:0] rs2_in,
    input  logic        branch_in,
    output logic        bus_req,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        mem_stall,
    output logic        redirect,
    output logic [29:0] redirect_pc,
    output logic [4:0]  mem_rd_address,
    output logic        mem_writes_rd,
    output logic        mem_is_load,
    output logic [31:0] mem_fwd_data,
    output logic        misaligned,
    output logic        bus_error,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // done_q: access finished while clk_en was low; result parked in ld_q/err_q
    logic          done_q, done_d;
    logic [31:0]   ld_q, ld_d;
    logic          err_q, err_d;

    logic          bus_req_q, bus_we_q;
    logic [29:0]   bus_addr_q;
    logic [3:0]    bus_be_q;
    logic [31:0]   bus_wdata_q;
    logic          misaligned_q, bus_error_q;
    logic          wb_valid_q;
    logic [4:0]    wb_rd_q;
    logic [31:0]   wb_data_q;

    logic [2:0]    fn3;
    logic [4:0]    rd;
    logic          mem_op, misal, writes_rd;
    logic [3:0]    be_d;
    logic [31:0]   wdata_d;
    logic [31:0]   shifted, ld_ext;
    logic          sx;
    logic          issue, finish, tmo;
    logic          mis_now, wb_load;
    logic [31:0]   wb_ld;
    logic          wb_err;
    logic          wb_valid_d;
    logic [31:0]   wb_data_d;

    assign fn3       = inst_in[14:12];
    assign rd        = inst_in[11:7];
    assign mem_op    = ctr_in[0] | ctr_in[1];
    assign writes_rd = ctr_in[2] && (rd != 5'd0);

    // Width decode, alignment check and store lane formatting
    always_comb begin
        misal   = 1'b0;
        be_d    = 4'b1111;
        wdata_d = rs2_in;
        unique case (fn3[1:0])
            2'd0: begin
                be_d    = 4'b0001 << alu_in[1:0];
                wdata_d = {4{rs2_in[7:0]}};
            end
            2'd1: begin
                misal   = alu_in[0];
                be_d    = 4'b0011 << alu_in[1:0];
                wdata_d = {2{rs2_in[15:0]}};
            end
            2'd2: begin
                misal   = (alu_in[1:0] != 2'd0);
            end
            default: begin
                misal   = 1'b1;
            end
        endcase
    end

    // Load lane select and extension
    always_comb begin
        shifted = bus_rdata >> {alu_in[1:0], 3'b000};
        sx      = !fn3[2];
        unique case (fn3[1:0])
            2'd0:    ld_ext = {{24{sx & shifted[7]}}, shifted[7:0]};
            2'd1:    ld_ext = {{16{sx & shifted[15]}}, shifted[15:0]};
            default: ld_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        ld_d      = ld_q;
        err_d     = err_q;
        mem_stall = 1'b0;
        issue     = 1'b0;
        finish    = 1'b0;
        tmo       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (done_q) begin
                    if (clk_en) done_d = 1'b0;
                end else if (clk_en && mem_op && !misal) begin
                    mem_stall = 1'b1;
                    issue     = 1'b1;
                    state_d   = BUSY;
                    cnt_d     = '0;
                end
            end
            BUSY: begin
                if (bus_ack) begin
                    finish = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    tmo    = 1'b1;
                    finish = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                end
                mem_stall = !bus_ack && !tmo;
                if (finish) begin
                    state_d = IDLE;
                    ld_d    = ld_ext;
                    err_d   = tmo;
                    if (!clk_en) done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Writeback source: parked result, finishing access, or plain ALU op
    assign mis_now = (state_q == IDLE) && !done_q && mem_op && misal;
    assign wb_load = clk_en && !mem_stall;
    assign wb_ld   = done_q ? ld_q : ld_ext;
    assign wb_err  = done_q ? err_q : tmo;

    always_comb begin
        wb_valid_d = writes_rd && !wb_err && !mis_now;
        unique case (ctr_in[4:3])
            2'd1:    wb_data_d = wb_ld;
            2'd2:    wb_data_d = {inc_pc_in, 2'b00};
            default: wb_data_d = alu_in;
        endcase
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            ld_q         <= '0;
            err_q        <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            ld_q         <= ld_d;
            err_q        <= err_d;
            misaligned_q <= clk_en && mis_now;
            bus_error_q  <= tmo;
            if (issue) begin
                bus_req_q   <= 1'b1;
                bus_we_q    <= ctr_in[1];
                bus_addr_q  <= alu_in[31:2];
                bus_be_q    <= be_d;
                bus_wdata_q <= wdata_d;
            end else if (finish) begin
                bus_req_q   <= 1'b0;
            end
            if (invalidate) begin
                wb_valid_q <= 1'b0;
            end else if (wb_load) begin
                wb_valid_q <= wb_valid_d;
            end
            if (wb_load) begin
                wb_rd_q   <= rd;
                wb_data_q <= wb_data_d;
            end
        end
    end

    assign bus_req        = bus_req_q;
    assign bus_we         = bus_we_q;
    assign bus_addr       = bus_addr_q;
    assign bus_be         = bus_be_q;
    assign bus_wdata      = bus_wdata_q;
    assign misaligned     = misaligned_q;
    assign bus_error      = bus_error_q;
    assign wb_valid       = wb_valid_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;

    assign redirect       = branch_in && !mem_stall && clk_en;
    assign redirect_pc    = alu_in[31:2];
    assign mem_rd_address = rd;
    assign mem_writes_rd  = writes_rd;
    assign mem_is_load    = ctr_in[0];
    assign mem_fwd_data   = (ctr_in[4:3] == 2'd2) ? {inc_pc_in, 2'b00} : alu_in;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage against an arithmetic reference model,
// plus directed cases for reset, clk_en hold and the documented examples.
module tb_memory_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        async_rst, clk_en, invalidate;
    logic [4:0]  ctr_in;
    logic [31:0] inst_in, alu_in, rs2_in;
    logic [29:0] inc_pc_in;
    logic        branch_in;
    logic        bus_req, bus_we, bus_ack;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata, bus_rdata;
    logic        mem_stall, redirect;
    logic [29:0] redirect_pc;
    logic [4:0]  mem_rd_address;
    logic        mem_writes_rd, mem_is_load;
    logic [31:0] mem_fwd_data;
    logic        misaligned, bus_error, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    memory_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
        .invalidate(invalidate), .ctr_in(ctr_in), .inst_in(inst_in),
        .alu_in(alu_in), .inc_pc_in(inc_pc_in), .rs2_in(rs2_in),
        .branch_in(branch_in), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .mem_stall(mem_stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_rd_address(mem_rd_address), .mem_writes_rd(mem_writes_rd),
        .mem_is_load(mem_is_load), .mem_fwd_data(mem_fwd_data),
        .misaligned(misaligned), .bus_error(bus_error),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: sizes in bytes, plain arithmetic
    function automatic logic mis_f(input logic [2:0] f, input logic [31:0] a);
        int n = 1 << f[1:0];
        return (f[1:0] == 2'd3) || ((a % n) != 0);
    endfunction

    function automatic logic [3:0] be_f(input logic [2:0] f,
                                        input logic [31:0] a);
        int n = 1 << f[1:0];
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] wd_f(input logic [2:0] f,
                                         input logic [31:0] d);
        int n = 1 << f[1:0];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ld_f(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] d);
        int n = 1 << f[1:0];
        longint m = (longint'(1) << (8 * n)) - 1;
        longint v = (longint'({32'b0, d}) >> (8 * (a % 4))) & m;
        if (!f[2] && v > (m >> 1)) v = v - (m + 1);
        return v[31:0];
    endfunction

    task automatic run_op(input logic [4:0] ctr, input logic [31:0] inst,
                          input logic [31:0] alu, input logic [29:0] ipc,
                          input logic [31:0] rs2, input logic br,
                          input logic inv, input int dly,
                          input logic [31:0] rdat);
        logic [2:0]  f   = inst[14:12];
        logic [4:0]  rd  = inst[11:7];
        logic        mem = ctr[0] | ctr[1];
        logic        mis = mem && mis_f(f, alu);
        logic        acc = mem && !mis;
        logic        to  = acc && (dly < 0 || dly >= TO);
        int          exp_st = !acc ? 0 : (to ? TO : dly + 1);
        int          st = 0;
        int          bc = 0;
        logic        done = 1'b0;
        logic        ev;
        logic [31:0] ed;
        @(negedge clk);
        ctr_in = ctr; inst_in = inst; alu_in = alu; inc_pc_in = ipc;
        rs2_in = rs2; branch_in = br; clk_en = 1'b1; invalidate = inv;
        bus_ack = 1'b0; bus_rdata = rdat;
        for (int c = 0; c < 100 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (bus_req) begin
                bc++;
                bus_ack = (dly >= 0 && bc == dly + 1);
                chk("bus_we", 32'(bus_we), 32'(ctr[1]));
                chk("bus_addr", 32'(bus_addr), 32'(alu >> 2));
                chk("bus_be", 32'(bus_be), 32'(be_f(f, alu)));
                chk("bus_wdata", bus_wdata, wd_f(f, rs2));
            end else begin
                bus_ack = 1'b0;
                if (!acc || c > 0) chk("bus_req_idle", 32'(bus_req), 32'd0);
            end
            #1;
            if (mem_stall) begin
                st++;
                chk("redirect_stall", 32'(redirect), 32'd0);
            end else begin
                done = 1'b1;
                chk("redirect", 32'(redirect), 32'(br));
                chk("redirect_pc", 32'(redirect_pc), 32'(alu >> 2));
                chk("fwd_rd", 32'(mem_rd_address), 32'(rd));
                chk("fwd_wr", 32'(mem_writes_rd),
                    32'(ctr[2] && rd != 5'd0));
                chk("fwd_ld", 32'(mem_is_load), 32'(ctr[0]));
                chk("fwd_data", mem_fwd_data,
                    ctr[4:3] == 2'd2 ? {ipc, 2'b00} : alu);
            end
        end
        chk("op_done", 32'(done), 32'd1);
        chk("stall_cnt", 32'(st), 32'(exp_st));
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        invalidate = 1'b0;
        ev = ctr[2] && rd != 5'd0 && !mis && !to && !inv;
        case (ctr[4:3])
            2'd1:    ed = ld_f(f, alu, rdat);
            2'd2:    ed = {ipc, 2'b00};
            default: ed = alu;
        endcase
        chk("req_after", 32'(bus_req), 32'd0);
        chk("misaligned", 32'(misaligned), 32'(mis));
        chk("bus_error", 32'(bus_error), 32'(to));
        chk("wb_valid", 32'(wb_valid), 32'(ev));
        if (ev) begin
            chk("wb_rd", 32'(wb_rd), 32'(rd));
            chk("wb_data", wb_data, ed);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [2:0] f,
                                            input logic [4:0] rd);
        return {17'd0, f, rd, 7'b0000011};
    endfunction

    initial begin
        logic [31:0] r;
        async_rst = 1'b1; clk_en = 1'b0; invalidate = 1'b0;
        ctr_in = '0; inst_in = '0; alu_in = '0; inc_pc_in = '0;
        rs2_in = '0; branch_in = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
        #12;
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        chk("rst_addr", 32'(bus_addr), 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_wbd", wb_data, 32'd0);
        chk("rst_err", 32'(bus_error | misaligned), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        @(negedge clk);
        async_rst = 1'b0;

        // SB to 0x103, ack on first busy cycle
        run_op(5'b00010, mk_inst(3'b000, 5'd0), 32'h103, 30'h0,
               32'hA5, 1'b0, 1'b0, 0, 32'h0);
        // LB / LBU from 0x102
        run_op(5'b01101, mk_inst(3'b000, 5'd5), 32'h102, 30'h0,
               32'h0, 1'b0, 1'b0, 1, 32'h0080_0000);
        run_op(5'b01101, mk_inst(3'b100, 5'd5), 32'h102, 30'h0,
               32'h0, 1'b0, 1'b0, 2, 32'h0080_0000);
        // LW with ack after 3 busy cycles (coincides with timeout cycle)
        run_op(5'b01101, mk_inst(3'b010, 5'd9), 32'h40, 30'h0,
               32'h0, 1'b0, 1'b0, 3, 32'hDEAD_BEEF);
        // LW misaligned
        run_op(5'b01101, mk_inst(3'b010, 5'd9), 32'h101, 30'h0,
               32'h0, 1'b0, 1'b0, 0, 32'h1234_5678);
        // No ack: timeout
        run_op(5'b01101, mk_inst(3'b010, 5'd4), 32'h80, 30'h0,
               32'h0, 1'b0, 1'b0, -1, 32'h0);
        // JAL
        run_op(5'b10100, mk_inst(3'b000, 5'd1), 32'h200, 30'h41,
               32'h0, 1'b1, 1'b0, 0, 32'h0);

        // Async reset while busy
        @(negedge clk);
        ctr_in = 5'b01101; inst_in = mk_inst(3'b010, 5'd3);
        alu_in = 32'h10; clk_en = 1'b1; branch_in = 1'b0;
        @(posedge clk);
        #1;
        chk("busy_req", 32'(bus_req), 32'd1);
        @(negedge clk);
        #1;
        async_rst = 1'b1;
        #1;
        chk("arst_req", 32'(bus_req), 32'd0);
        chk("arst_wbv", 32'(wb_valid), 32'd0);
        clk_en = 1'b0;
        @(negedge clk);
        async_rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_idle", 32'(bus_req), 32'd0);

        // Access completes with clk_en low; result written on clk_en high
        r = 32'hCAFE_0042;
        @(negedge clk);
        ctr_in = 5'b01101; inst_in = mk_inst(3'b010, 5'd7);
        alu_in = 32'h24; clk_en = 1'b1; bus_rdata = r;
        @(posedge clk);
        #1;
        chk("hold_busy", 32'(bus_req), 32'd1);
        @(negedge clk);
        clk_en = 1'b0; bus_ack = 1'b1;
        #1;
        chk("hold_ackstall", 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        chk("hold_req", 32'(bus_req), 32'd0);
        chk("hold_wbv0", 32'(wb_valid), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("hold_stall", 32'(mem_stall), 32'd0);
        end
        @(negedge clk);
        clk_en = 1'b1;
        bus_rdata = 32'h0;
        #1;
        chk("hold_en_stall", 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;
        chk("hold_wbv", 32'(wb_valid), 32'd1);
        chk("hold_wbd", wb_data, r);
        chk("hold_noreq", 32'(bus_req), 32'd0);

        // Random traffic
        for (int k = 0; k < 120; k++) begin
            int          op;
            logic [4:0]  c;
            logic [31:0] ins;
            op  = int'($urandom_range(0, 2));
            ins = $urandom;
            case (op)
                0: c = {($urandom_range(0, 1) != 0) ? 2'd2 : 2'd0,
                        1'($urandom), 2'b00};
                1: c = 5'b01101;
                default: c = 5'b00010;
            endcase
            run_op(c, ins, $urandom, 30'($urandom), $urandom,
                   1'($urandom), ($urandom_range(0, 7) == 0),
                   int'($urandom_range(0, 6)) - 1, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
